// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its digit cells.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    // Out-of-range load digits saturate at 9 so cnt can never hold a non-BCD digit.
    function automatic logic [BCD_W-1:0] sanitize_bcd(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Start/abort/tick request side and count/status side of the BCD countdown timer.
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  abort;
    logic                  tick;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   cnt;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, tick, load_val,
        input  cnt, busy, done
    );

    modport slave (
        input  start, abort, tick, load_val,
        output cnt, busy, done
    );
endinterface

// File: rtl/bcd_digit_down.sv
// Single registered BCD digit that decrements with borrow chaining and wraps 0 -> 9.
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             dec,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);
    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (ld) begin
            digit_d = ld_val;
        end else if (dec && borrow_in) begin
            digit_d = (digit_q == '0) ? BCD_MAX : (digit_q - 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = (digit_q == '0) && borrow_in;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with start/abort handshake and one-cycle done pulse.
// Define BCD_CNTDN_AUTO_RELOAD_EN to make DONE reload the last preset and run again.
//
//   state | meaning
//   IDLE  | waiting for start; cnt holds its last value
//   RUN   | decrementing once per tick
//   DONE  | count reached zero; done asserted for this one cycle
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    bcd_countdown_timer_if.slave   bus
);
    localparam int CW = BCD_W * DIGITS;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   load_san;
    logic [CW-1:0]   ld_val_mux;
    logic [CW-1:0]   cnt;
    logic [DIGITS:0] borrow;
    logic            ld;
    logic            dec;
    logic            load_zero;
    logic            cnt_is_one;
    logic            unused_borrow;

`ifdef BCD_CNTDN_AUTO_RELOAD_EN
    logic [CW-1:0]   reload_q;
    logic [CW-1:0]   reload_d;
`endif

    assign load_zero     = (load_san == '0);
    assign cnt_is_one    = (cnt == CW'(1));
    assign borrow[0]     = 1'b1;
    assign unused_borrow = borrow[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign load_san[i*BCD_W +: BCD_W] = sanitize_bcd(bus.load_val[i*BCD_W +: BCD_W]);

        bcd_digit_down u_digit (
            .clk        (clk),
            .rstn       (rstn),
            .ld         (ld),
            .ld_val     (ld_val_mux[i*BCD_W +: BCD_W]),
            .dec        (dec),
            .borrow_in  (borrow[i]),
            .digit      (cnt[i*BCD_W +: BCD_W]),
            .borrow_out (borrow[i+1])
        );
    end

    // abort outranks start everywhere; start outranks tick and any reload.
    always_comb begin
        state_d    = state_q;
        ld         = 1'b0;
        dec        = 1'b0;
        ld_val_mux = load_san;
`ifdef BCD_CNTDN_AUTO_RELOAD_EN
        reload_d   = reload_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    ld      = 1'b1;
                    state_d = load_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    ld      = 1'b1;
                    state_d = load_zero ? DONE : RUN;
                end else if (bus.tick) begin
                    dec = 1'b1;
                    if (cnt_is_one) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    ld      = 1'b1;
                    state_d = load_zero ? DONE : RUN;
                end else begin
`ifdef BCD_CNTDN_AUTO_RELOAD_EN
                    if (reload_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        ld         = 1'b1;
                        ld_val_mux = reload_q;
                        state_d    = RUN;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BCD_CNTDN_AUTO_RELOAD_EN
        if (ld && (ld_val_mux == load_san) && bus.start && !bus.abort) begin
            reload_d = load_san;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef BCD_CNTDN_AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign bus.cnt  = cnt;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);

endmodule
